eth_phy_link_seq: RTL and testbench
===================================

Name: eth_phy_link_seq

Overview:
- Parametrised bring-up and link-supervision sequencer for CH_COUNT 10G Ethernet PHY channels sharing one QPLL.
- Sequences the shared PLL reset and then the per-channel PHY resets.
- Qualifies each channel's rx_block_lock and retries channels that fail to lock within a timeout.
- Reports per-channel and aggregate link state and drives one status LED per channel. Sits in the top level between the transceiver PHY wrappers and the core, clocked by the free-running control clock.

Parameters:
CH_COUNT, 4, number of PHY channels (1..16)
SYNC_STAGES, 2, synchroniser flops on every asynchronous input (>=2)
PLL_RST_CYCLES, 64, cycles pll_rst_out is held high per PLL reset attempt
PLL_TIMEOUT_CYCLES, 1000000, cycles to wait for PLL lock before re-resetting the PLL
CH_RST_CYCLES, 64, cycles ch_rst_out[i] is held high per channel reset attempt
LOCK_CYCLES, 4096, consecutive locked-and-not-high-BER cycles required to declare link up
LOCK_TIMEOUT_CYCLES, 1000000, cycles in wait before a channel is reset and retried
DROP_CYCLES, 16, consecutive bad cycles (lock low or high_ber) that drop an up link
BLINK_CYCLES, 8000000, LED half-period while a channel is waiting for lock

Ports:
clk  in  1  control clock; all logic in this domain
rst_n  in  1  reset
pll_lock_in  in  1  QPLL lock, asynchronous
ch_rx_block_lock  in  CH_COUNT  per-channel block lock, asynchronous
ch_rx_high_ber  in  CH_COUNT  per-channel high BER, asynchronous
pll_rst_out  out  1  QPLL reset, active high
ch_rst_out  out  CH_COUNT  per-channel PHY reset, active high
ch_link_up  out  CH_COUNT  channel qualified up
all_link_up  out  1  AND of ch_link_up
led_out  out  CH_COUNT  status LEDs
ch_retry_count  out  8*CH_COUNT  per-channel saturating retry counters (only with the optional feature)

Behaviour:
- Interface (decided): one clock, clk; asynchronous active-low reset, rst_n. All state is cleared asynchronously on rst_n low; logic runs from the first clk edge after rst_n is released.
- Reset values: pll_rst_out=1, ch_rst_out all 1, ch_link_up=0, all_link_up=0, led_out=0, ch_retry_count=0. Global FSM=G_PLL_RST, all channel FSMs=CH_RST, all counters 0.
- Inputs pass through SYNC_STAGES flops before use; all latencies below are measured from the synchronised value.
- Outputs are registered.
- Counter widths are $clog2(limit+1). Each FSM has one counter that clears on every state entry.
- Global FSM:
  - G_PLL_RST: pll_rst_out=1. After PLL_RST_CYCLES cycles, go to G_PLL_WAIT.
  - G_PLL_WAIT: pll_rst_out=0. Synced lock=1 -> G_RUN next cycle. Counter reaching PLL_TIMEOUT_CYCLES -> G_PLL_RST.
  - G_RUN: synced lock=0 -> G_PLL_RST, and all channels are forced to CH_RST on the same edge.
- Channel FSM (one per channel, held in CH_RST while the global FSM is not in G_RUN):
  - CH_RST: ch_rst_out=1. After CH_RST_CYCLES cycles in CH_RST with the global FSM in G_RUN -> CH_WAIT.
  - CH_WAIT: ch_rst_out=0.
    - A good cycle is lock=1 and high_ber=0. A good-run counter counts consecutive good cycles and clears on any bad cycle.
    - Good-run reaching LOCK_CYCLES -> CH_UP.
    - Else, timeout counter reaching LOCK_TIMEOUT_CYCLES -> CH_RST and retry++.
    - Lock qualification and timeout in the same cycle: lock wins.
  - CH_UP: ch_link_up=1. A bad-run counter counts consecutive bad cycles and clears on any good cycle. Bad-run reaching DROP_CYCLES -> CH_RST, with no retry increment.
- Priority: PLL loss > drop/timeout > qualification.
- all_link_up: registered AND of ch_link_up, one cycle behind it.
- led_out[i]: 0 in CH_RST, 1 in CH_UP. In CH_WAIT it follows a shared free-running blink toggle (toggles every BLINK_CYCLES).
- rst_n asserted mid-operation returns everything to reset values immediately, regardless of clk.

Optional Feature:
- Macro ETH_PHY_LINK_SEQ_RETRY_STATS_EN.
- Defined:
  - ch_retry_count is present.
  - One 8-bit counter per channel increments on each CH_WAIT timeout and saturates at 255.
  - Channel i occupies bits [8i+7:8i].
  - Cleared only by rst_n.
- Undefined: the port and the counters are absent.

Decomposition:
- Package eth_phy_link_seq_pkg holds:
  - global-state and channel-state encodings: G_PLL_RST/G_PLL_WAIT/G_RUN and CH_RST/CH_WAIT/CH_UP;
  - the retry counter width (8).
- Sub-module eth_phy_link_seq_ch contains one channel FSM, its counters and the retry counter; it is instantiated CH_COUNT times in a generate loop.
- The top level holds the synchronisers, global FSM, blink counter and all_link_up.

Test Plan (CH_COUNT=4, SYNC_STAGES=2, PLL_RST_CYCLES=4, PLL_TIMEOUT_CYCLES=64, CH_RST_CYCLES=8, LOCK_CYCLES=16, LOCK_TIMEOUT_CYCLES=100, DROP_CYCLES=4, BLINK_CYCLES=8):
1. PLL bring-up: release rst_n, hold pll_lock_in=1 -> pll_rst_out high for 4 cycles; G_RUN reached; ch_rst_out drops 8 cycles later.
2. Channel qualification: all block locks high, high_ber low -> ch_link_up=4'hF 16 cycles after CH_WAIT entry (+2 sync); all_link_up one cycle later; led_out=4'hF.
3. Retry and PLL timeout:
   - ch2 lock held low -> ch_rst_out[2] pulses 8 cycles every 108 cycles; led_out[2] blinks with period 16 in CH_WAIT; retry count of ch2 = 3 after three timeouts (with macro).
   - pll_lock_in held low -> PLL re-reset every 68 cycles.
4. Drop filtering:
   - On an up ch0, a 3-cycle lock glitch -> ch_link_up[0] stays 1.
   - A 4-cycle glitch -> ch_link_up[0]=0 and ch0 re-enters CH_RST; retry count unchanged.
   - Same with high_ber=1 for 4 cycles.
5. PLL loss and reset:
   - With all channels up, drop pll_lock_in -> all ch_link_up=0, ch_rst_out=4'hF and pll_rst_out=1 on the same edge.
   - Assert rst_n mid-CH_WAIT -> all outputs at reset values without a clk edge.
6. Boundaries:
   - Good-run reaches 16 on the same cycle the timeout reaches 100 -> CH_UP, no retry.
   - Retry counter driven past 255 -> holds 255.

Source files
------------

// File: rtl/eth_phy_link_seq_pkg.sv
// eth_phy_link_seq_pkg: shared state encodings and retry counter width for the PHY link sequencer.
package eth_phy_link_seq_pkg;
  typedef enum logic [1:0] {G_PLL_RST, G_PLL_WAIT, G_RUN} g_state_t;
  typedef enum logic [1:0] {CH_RST, CH_WAIT, CH_UP} ch_state_t;
  localparam int RETRY_W = 8;
endpackage

// File: rtl/eth_phy_link_seq_ch.sv
// eth_phy_link_seq_ch: one channel reset/lock-qualification FSM with drop filter and status LED.
// Retry statistics counter present only when ETH_PHY_LINK_SEQ_RETRY_STATS_EN is defined.
module eth_phy_link_seq_ch import eth_phy_link_seq_pkg::*; #(
  parameter int CH_RST_CYCLES       = 64,
  parameter int LOCK_CYCLES         = 4096,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int DROP_CYCLES         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic blink,
  input  logic lock,
  input  logic ber,
  output logic phy_rst,
  output logic link_up,
  output logic led
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
  , output logic [RETRY_W-1:0] retry
`endif
);
  localparam int CW = $clog2((CH_RST_CYCLES > LOCK_TIMEOUT_CYCLES ? CH_RST_CYCLES : LOCK_TIMEOUT_CYCLES) + 1);
  localparam int RW = $clog2((LOCK_CYCLES > DROP_CYCLES ? LOCK_CYCLES : DROP_CYCLES) + 1);
  ch_state_t state, next;
  logic [CW-1:0] cnt, cnt_next;
  logic [RW-1:0] run, run_next;
  logic good;
  // run counts consecutive good cycles in CH_WAIT and consecutive bad cycles in CH_UP
  always_comb begin
    good = lock & ~ber;
    next = state;
    cnt_next = cnt + 1'b1;
    run_next = '0;
    if (!en) next = CH_RST;
    else
      case (state)
        CH_RST: next = cnt == CW'(CH_RST_CYCLES - 1) ? CH_WAIT : CH_RST;
        CH_WAIT: begin
          run_next = good ? run + 1'b1 : '0;
          next = good && run == RW'(LOCK_CYCLES - 1) ? CH_UP :
                 cnt == CW'(LOCK_TIMEOUT_CYCLES - 1) ? CH_RST : CH_WAIT;
        end
        CH_UP: begin
          run_next = good ? '0 : run + 1'b1;
          next = !good && run == RW'(DROP_CYCLES - 1) ? CH_RST : CH_UP;
        end
        default: next = CH_RST;
      endcase
    if (next != state || !en || state == CH_UP) cnt_next = '0;
    if (next != state) run_next = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CH_RST;
      cnt <= '0;
      run <= '0;
      phy_rst <= 1'b1;
      link_up <= 1'b0;
      led <= 1'b0;
    end else begin
      state <= next;
      cnt <= cnt_next;
      run <= run_next;
      phy_rst <= next == CH_RST;
      link_up <= next == CH_UP;
      led <= next == CH_UP || (next == CH_WAIT && blink);
    end
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
  // with en high, the only CH_WAIT -> CH_RST path is the lock timeout
  logic timeout;
  assign timeout = en && state == CH_WAIT && next == CH_RST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retry <= '0;
    else if (timeout && retry != '1) retry <= retry + 1'b1;
`endif
endmodule

// File: rtl/eth_phy_link_seq.sv
// eth_phy_link_seq: shared-QPLL and per-channel 10G PHY bring-up/link supervision sequencer.
// Define ETH_PHY_LINK_SEQ_RETRY_STATS_EN to add per-channel saturating retry counters.
module eth_phy_link_seq import eth_phy_link_seq_pkg::*; #(
  parameter int CH_COUNT            = 4,
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 64,
  parameter int PLL_TIMEOUT_CYCLES  = 1000000,
  parameter int CH_RST_CYCLES       = 64,
  parameter int LOCK_CYCLES         = 4096,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int DROP_CYCLES         = 16,
  parameter int BLINK_CYCLES        = 8000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_lock_in,
  input  logic [CH_COUNT-1:0] ch_rx_block_lock,
  input  logic [CH_COUNT-1:0] ch_rx_high_ber,
  output logic                pll_rst_out,
  output logic [CH_COUNT-1:0] ch_rst_out,
  output logic [CH_COUNT-1:0] ch_link_up,
  output logic                all_link_up,
  output logic [CH_COUNT-1:0] led_out
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
  , output logic [RETRY_W*CH_COUNT-1:0] ch_retry_count
`endif
);
  localparam int GW = $clog2((PLL_RST_CYCLES > PLL_TIMEOUT_CYCLES ? PLL_RST_CYCLES : PLL_TIMEOUT_CYCLES) + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [SYNC_STAGES-1:0] pll_sync;
  logic [SYNC_STAGES-1:0][CH_COUNT-1:0] lock_sync, ber_sync;
  logic pll_s, en, blink;
  logic [CH_COUNT-1:0] lock_s, ber_s;
  g_state_t g_state, g_next;
  logic [GW-1:0] g_cnt, g_cnt_next;
  logic [BW-1:0] blink_cnt;
  assign pll_s = pll_sync[SYNC_STAGES-1];
  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign ber_s = ber_sync[SYNC_STAGES-1];
  // channels drop to reset on the same edge the PLL loss sends the global FSM back
  assign en = g_state == G_RUN && pll_s;
  always_comb begin
    g_next = g_state;
    case (g_state)
      G_PLL_RST: g_next = g_cnt == GW'(PLL_RST_CYCLES - 1) ? G_PLL_WAIT : G_PLL_RST;
      G_PLL_WAIT: g_next = pll_s ? G_RUN : g_cnt == GW'(PLL_TIMEOUT_CYCLES - 1) ? G_PLL_RST : G_PLL_WAIT;
      G_RUN: g_next = pll_s ? G_RUN : G_PLL_RST;
      default: g_next = G_PLL_RST;
    endcase
    g_cnt_next = (g_next != g_state || g_state == G_RUN) ? '0 : g_cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pll_sync <= '0;
      lock_sync <= '0;
      ber_sync <= '0;
      g_state <= G_PLL_RST;
      g_cnt <= '0;
      pll_rst_out <= 1'b1;
      blink_cnt <= '0;
      blink <= 1'b0;
      all_link_up <= 1'b0;
    end else begin
      pll_sync <= {pll_sync[SYNC_STAGES-2:0], pll_lock_in};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], ch_rx_block_lock};
      ber_sync <= {ber_sync[SYNC_STAGES-2:0], ch_rx_high_ber};
      g_state <= g_next;
      g_cnt <= g_cnt_next;
      pll_rst_out <= g_next == G_PLL_RST;
      blink_cnt <= blink_cnt == BW'(BLINK_CYCLES - 1) ? '0 : blink_cnt + 1'b1;
      blink <= blink_cnt == BW'(BLINK_CYCLES - 1) ? ~blink : blink;
      all_link_up <= &ch_link_up;
    end
  for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
    eth_phy_link_seq_ch #(
      .CH_RST_CYCLES(CH_RST_CYCLES),
      .LOCK_CYCLES(LOCK_CYCLES),
      .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
      .DROP_CYCLES(DROP_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .blink(blink),
      .lock(lock_s[i]),
      .ber(ber_s[i]),
      .phy_rst(ch_rst_out[i]),
      .link_up(ch_link_up[i]),
      .led(led_out[i])
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
      , .retry(ch_retry_count[RETRY_W*i +: RETRY_W])
`endif
    );
  end
endmodule

// File: tb/tb_eth_phy_link_seq.sv
// tb_eth_phy_link_seq: directed self-checking bench for eth_phy_link_seq with small timing parameters.
module tb_eth_phy_link_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock_in = 1'b1;
  logic [3:0] ch_rx_block_lock = 4'hF;
  logic [3:0] ch_rx_high_ber = 4'h0;
  logic pll_rst_out, all_link_up;
  logic [3:0] ch_rst_out, ch_link_up, led_out;
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
  logic [31:0] ch_retry_count;
`endif
  int checks = 0;
  int errors = 0;
  int n, ones, lo;

  eth_phy_link_seq #(
    .CH_COUNT(4), .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .PLL_TIMEOUT_CYCLES(64),
    .CH_RST_CYCLES(8), .LOCK_CYCLES(16), .LOCK_TIMEOUT_CYCLES(100),
    .DROP_CYCLES(4), .BLINK_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock_in(pll_lock_in),
    .ch_rx_block_lock(ch_rx_block_lock),
    .ch_rx_high_ber(ch_rx_high_ber),
    .pll_rst_out(pll_rst_out),
    .ch_rst_out(ch_rst_out),
    .ch_link_up(ch_link_up),
    .all_link_up(all_link_up),
    .led_out(led_out)
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
    , .ch_retry_count(ch_retry_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_all_up();
    int w = 0;
    while (ch_link_up != 4'hF && w < 300) begin
      tick(1);
      w++;
    end
    chk("wait_all_up", {28'd0, ch_link_up}, 32'hF);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pll_rst"}, {31'd0, pll_rst_out}, 1);
    chk({tag, "_ch_rst"}, {28'd0, ch_rst_out}, 32'hF);
    chk({tag, "_link"}, {28'd0, ch_link_up}, 0);
    chk({tag, "_all"}, {31'd0, all_link_up}, 0);
    chk({tag, "_led"}, {28'd0, led_out}, 0);
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
    chk({tag, "_retry"}, ch_retry_count, 0);
`endif
  endtask

  initial begin
    #23;
    chk_reset_outputs("reset");
    // bring-up: edge k below means the k-th posedge after release
    @(negedge clk) rst_n = 1'b1;
    tick(3);
    chk("pll_rst_e3", {31'd0, pll_rst_out}, 1);
    tick(1);
    chk("pll_rst_e4", {31'd0, pll_rst_out}, 0);
    tick(8);
    chk("ch_rst_e12", {28'd0, ch_rst_out}, 32'hF);
    tick(1);
    chk("ch_rst_e13", {28'd0, ch_rst_out}, 0);
    tick(15);
    chk("link_e28", {28'd0, ch_link_up}, 0);
    tick(1);
    chk("link_e29", {28'd0, ch_link_up}, 32'hF);
    chk("all_e29", {31'd0, all_link_up}, 0);
    chk("led_up", {28'd0, led_out}, 32'hF);
    tick(1);
    chk("all_e30", {31'd0, all_link_up}, 1);

    // ch2 loses lock: drop, then 8-cycle resets every 108 cycles
    ch_rx_block_lock[2] = 1'b0;
    n = 0;
    while (!ch_rst_out[2] && n < 20) begin tick(1); n++; end
    chk("ch2_dropped", {28'd0, ch_link_up}, 32'hB);
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
    chk("ch2_drop_noretry", {24'd0, ch_retry_count[23:16]}, 0);
`endif
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (ch_rst_out[2] && n < 300) begin tick(1); n++; end
      chk("ch2_rst_pulse", n, 8);
      n = 0;
      ones = 0;
      while (!ch_rst_out[2] && n < 300) begin
        if (n < 16) ones += int'(led_out[2]);
        tick(1);
        n++;
      end
      chk("ch2_wait_len", n, 100);
      if (r == 0) chk("ch2_blink_ones", ones, 8);
    end
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
    chk("ch2_retry3", {24'd0, ch_retry_count[23:16]}, 3);
    chk("ch0_retry0", {24'd0, ch_retry_count[7:0]}, 0);
`endif
    ch_rx_block_lock[2] = 1'b1;
    wait_all_up();
    tick(1);
    chk("all_after_ch2", {31'd0, all_link_up}, 1);

    // PLL loss takes everything down on one edge, then PLL retries every 68 cycles
    pll_lock_in = 1'b0;
    n = 0;
    while (!pll_rst_out && n < 10) begin tick(1); n++; end
    chk("loss_pll_rst", {31'd0, pll_rst_out}, 1);
    chk("loss_link", {28'd0, ch_link_up}, 0);
    chk("loss_ch_rst", {28'd0, ch_rst_out}, 32'hF);
    chk("loss_all_lag", {31'd0, all_link_up}, 1);
    n = 0;
    while (pll_rst_out && n < 200) begin tick(1); n++; end
    chk("loss_all_next", {31'd0, all_link_up}, 0);
    chk("pll_rst_len", n, 4);
    n = 0;
    while (!pll_rst_out && n < 200) begin tick(1); n++; end
    chk("pll_wait_len", n, 64);
    pll_lock_in = 1'b1;
    wait_all_up();

    // drop filter on ch0: 3 bad cycles tolerated, 4 drop the link
    ch_rx_block_lock[0] = 1'b0;
    tick(3);
    ch_rx_block_lock[0] = 1'b1;
    lo = 0;
    repeat (10) begin tick(1); if (!ch_link_up[0]) lo++; end
    chk("glitch3_kept", lo, 0);
    ch_rx_block_lock[0] = 1'b0;
    tick(4);
    ch_rx_block_lock[0] = 1'b1;
    n = 0;
    while (ch_link_up[0] && n < 10) begin tick(1); n++; end
    chk("glitch4_link", {31'd0, ch_link_up[0]}, 0);
    chk("glitch4_rst", {31'd0, ch_rst_out[0]}, 1);
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
    chk("glitch4_noretry", {24'd0, ch_retry_count[7:0]}, 0);
`endif
    wait_all_up();
    ch_rx_high_ber[0] = 1'b1;
    tick(4);
    ch_rx_high_ber[0] = 1'b0;
    n = 0;
    while (ch_link_up[0] && n < 10) begin tick(1); n++; end
    chk("ber4_link", {31'd0, ch_link_up[0]}, 0);
    chk("ber4_rst", {31'd0, ch_rst_out[0]}, 1);

    // asynchronous reset while ch0 is in CH_WAIT
    n = 0;
    while (ch_rst_out[0] && n < 20) begin tick(1); n++; end
    chk("ch0_in_wait", {31'd0, ch_rst_out[0]}, 0);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("async");

    // lock qualification and timeout on the same edge: lock wins
    ch_rx_block_lock = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick(95);
    ch_rx_block_lock = 4'hF;
    tick(17);
    chk("bound_link_e112", {28'd0, ch_link_up}, 0);
    chk("bound_rst_e112", {28'd0, ch_rst_out}, 0);
    tick(1);
    chk("bound_link_e113", {28'd0, ch_link_up}, 32'hF);
    chk("bound_rst_e113", {28'd0, ch_rst_out}, 0);
`ifdef ETH_PHY_LINK_SEQ_RETRY_STATS_EN
    chk("bound_noretry", ch_retry_count, 0);
    ch_rx_block_lock[2] = 1'b0;
    tick(260 * 108 + 50);
    chk("ch2_retry_sat", {24'd0, ch_retry_count[23:16]}, 255);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
